// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared widths, constants and state codes for the MIPS
//                general-purpose register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int REG_BUS_W    = 32;   // RegBus
  localparam int REG_ADDR_W   = 5;    // RegAddrBus
  localparam int REG_NUM      = 32;   // RegNum
  localparam int REG_NUM_LOG2 = 5;    // RegNumLog2

  localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
  localparam logic                  WRITE_ENABLE = 1'b1;
  localparam logic                  READ_ENABLE  = 1'b1;
  localparam logic                  RST_ENABLE   = 1'b0;

  // Sweep FSM state codes
  typedef enum logic [1:0] {
    RF_INIT = 2'b00,
    RF_RUN  = 2'b01
  } rf_state_e;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_if
//  Description : Write-back write port and decode-stage read ports of the
//                register file. master = pipeline side, slave = regfile.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W
);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output we, waddr, wdata,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2
  );

endinterface : regfile_if
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
//  Module      : regfile
//  Description : MIPS register file, one write port and two combinational
//                read ports with same-cycle write-back bypass. Contents are
//                cleared after reset by a one-entry-per-cycle sweep, during
//                which init_busy_o stalls the pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REG_BUS_W,
  parameter int ADDR_W   = REG_NUM_LOG2,
  parameter int NUM_REGS = REG_NUM      // must equal 2**ADDR_W
) (
  input  wire logic    clk,
  input  wire logic    rst,             // synchronous, active-low
  regfile_if.slave     bus,
  output      logic    init_busy_o
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(NOP_REG_ADDR);
  localparam logic [DATA_W-1:0] ZERO_VAL = DATA_W'(ZERO_WORD);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] sweep_ptr_q, sweep_ptr_d;
  logic              init_busy_q, init_busy_d;

  // Sweep FSM state, pointer and busy flag registers
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q     <= RF_INIT;
      sweep_ptr_q <= '0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sweep_ptr_q <= sweep_ptr_d;
      init_busy_q <= init_busy_d;
    end
  end

  // Sweep FSM next state: walk every entry once, then freeze the pointer in RUN
  always_comb begin
    state_d     = state_q;
    sweep_ptr_d = sweep_ptr_q;
    init_busy_d = init_busy_q;
    case (state_q)
      RF_INIT: begin
        init_busy_d = 1'b1;
        if (sweep_ptr_q == LAST_PTR) begin
          state_d     = RF_RUN;
          init_busy_d = 1'b0;
        end else begin
          sweep_ptr_d = sweep_ptr_q + 1'b1;
        end
      end
      RF_RUN: begin
        init_busy_d = 1'b0;
      end
      default: begin
        state_d     = RF_INIT;
        sweep_ptr_d = '0;
        init_busy_d = 1'b1;
      end
    endcase
  end

  // Single write port: the sweep owns it in INIT, write-back owns it in RUN.
  // No reset on the array itself; the sweep is what clears it.
  always_ff @(posedge clk) begin
    if (rst != RST_ENABLE) begin
      if (state_q == RF_INIT) begin
        mem_q[sweep_ptr_q] <= ZERO_VAL;
      end else if (state_q == RF_RUN && bus.we == WRITE_ENABLE && bus.waddr != ZERO_REG) begin
        mem_q[bus.waddr] <= bus.wdata;
      end
    end
  end

  // One read port: $0 and idle ports read zero, a matching write is forwarded
  function automatic logic [DATA_W-1:0] read_port(
    input logic              re,
    input logic [ADDR_W-1:0] raddr,
    input logic [DATA_W-1:0] mem_word
  );
    logic [DATA_W-1:0] rd;
    rd = ZERO_VAL;
    if (rst == RST_ENABLE || state_q != RF_RUN) begin
      rd = ZERO_VAL;
    end else if (raddr == ZERO_REG) begin
      rd = ZERO_VAL;
    end else if (re == READ_ENABLE && bus.we == WRITE_ENABLE && bus.waddr == raddr) begin
      rd = bus.wdata;
    end else if (re == READ_ENABLE) begin
      rd = mem_word;
    end
    return rd;
  endfunction

  // Two identical zero-latency read muxes
  always_comb begin
    bus.rdata1 = read_port(bus.re1, bus.raddr1, mem_q[bus.raddr1]);
    bus.rdata2 = read_port(bus.re2, bus.raddr2, mem_q[bus.raddr2]);
  end

  assign init_busy_o = init_busy_q;

endmodule : regfile
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile
//  Description : Directed self-checking bench for the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile;

  logic clk;
  logic rst;
  logic init_busy_o;

  int n_checks;
  int n_fail;

  regfile_if bus ();

  regfile dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .init_busy_o (init_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Counts edges with init_busy_o high after rst has been released, bounded
  task automatic count_busy(output int edges);
    edges = 0;
    while (init_busy_o === 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic idle_inputs();
    bus.we     = 1'b0;
    bus.waddr  = '0;
    bus.wdata  = '0;
    bus.re1    = 1'b0;
    bus.raddr1 = '0;
    bus.re2    = 1'b0;
    bus.raddr2 = '0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we    = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    @(negedge clk);
    bus.we    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 1; a < 32; a++) begin
      bus.re1    = 1'b1;
      bus.raddr1 = 5'(a);
      bus.re2    = 1'b1;
      bus.raddr2 = 5'(31 - a + 1);
      #1;
      check($sformatf("%s_p1_r%0d", tag, a), bus.rdata1, 32'h0);
      check($sformatf("%s_p2_r%0d", tag, 32 - a), bus.rdata2, 32'h0);
    end
    bus.re1 = 1'b0;
    bus.re2 = 1'b0;
  endtask

  initial begin
    int edges;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    idle_inputs();

    // ---------------- 1: reset then idle ----------------
    @(negedge clk);
    @(negedge clk);
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    #1;
    check("rst_busy", 32'(init_busy_o), 32'h1);
    check("rst_rdata1", bus.rdata1, 32'h0);
    bus.re1 = 1'b0;
    rst = 1'b1;
    count_busy(edges);
    check("init_busy_edges", 32'(edges), 32'd32);
    check("busy_after_init", 32'(init_busy_o), 32'h0);
    check_all_zero("init_clear");

    // ---------------- 2: write then read ----------------
    write_reg(5'd5, 32'hDEADBEEF);
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    #1;
    check("rd_r5", bus.rdata1, 32'hDEADBEEF);
    bus.re1 = 1'b0;
    #1;
    check("rd_r5_re0", bus.rdata1, 32'h0);

    // ---------------- 3: $0 rules ----------------
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
    bus.re1 = 1'b1; bus.raddr1 = 5'd0;
    bus.re2 = 1'b1; bus.raddr2 = 5'd0;
    #1;
    check("r0_wcyc_p1", bus.rdata1, 32'h0);
    check("r0_wcyc_p2", bus.rdata2, 32'h0);
    @(negedge clk);
    bus.we = 1'b0;
    #1;
    check("r0_after_p1", bus.rdata1, 32'h0);
    check("r0_after_p2", bus.rdata2, 32'h0);
    bus.re1 = 1'b0; bus.re2 = 1'b0;

    // ---------------- 4: write-first bypass ----------------
    write_reg(5'd7, 32'h1);
    bus.re2 = 1'b1; bus.raddr2 = 5'd7;
    bus.re1 = 1'b1; bus.raddr1 = 5'd7;
    #1;
    check("r7_before", bus.rdata2, 32'h1);
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h2;
    #1;
    check("bypass_p2", bus.rdata2, 32'h2);
    check("bypass_p1", bus.rdata1, 32'h2);
    bus.re1 = 1'b0;
    #1;
    check("bypass_re0", bus.rdata1, 32'h0);
    @(negedge clk);
    bus.we = 1'b0;
    #1;
    check("r7_after", bus.rdata2, 32'h2);
    bus.re2 = 1'b0;

    // ---------------- 5: writes during INIT are dropped ----------------
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'hA5A5A5A5;
    bus.re1 = 1'b1; bus.raddr1 = 5'd3;
    #1;
    check("init_rd_bypass_blocked", bus.rdata1, 32'h0);
    edges = 0;
    while (init_busy_o === 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
      if (edges == 20) begin
        #1;
        check("init_busy_mid", 32'(init_busy_o), 32'h1);
        check("init_rd_mid", bus.rdata1, 32'h0);
      end
    end
    bus.we = 1'b0;
    check("init2_busy_edges", 32'(edges), 32'd32);
    #1;
    check("r3_after_init", bus.rdata1, 32'h0);
    bus.raddr1 = 5'd5;
    #1;
    check("r5_cleared", bus.rdata1, 32'h0);
    bus.raddr1 = 5'd7;
    #1;
    check("r7_cleared", bus.rdata1, 32'h0);
    bus.re1 = 1'b0;

    // ---------------- 6: reset mid-sweep ----------------
    write_reg(5'd9, 32'h12345678);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    count_busy(edges);
    check("restart_busy_edges", 32'(edges), 32'd32);
    check_all_zero("restart_clear");
    write_reg(5'd31, 32'hCAFEF00D);
    bus.re2 = 1'b1; bus.raddr2 = 5'd31;
    #1;
    check("r31_after_restart", bus.rdata2, 32'hCAFEF00D);
    bus.re2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile
`default_nettype wire
